// File: rtl/ex_branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// ex_branch_resolve_pkg
//   Shared encodings for the EX-stage branch path. The EX control decode
//   produces branch_alu_op with these same constants, so both sides agree
//   on the 3-bit code without duplicating literals.
//   Contents: br_op_e (branch_alu_op encodings), state_e (resolve FSM),
//             word_aligned() helper.
// ---------------------------------------------------------------------------
package ex_branch_resolve_pkg;

   typedef enum logic [2:0] {
      BR_EQ   = 3'b000,
      BR_NE   = 3'b001,
      BR_JUMP = 3'b010,
      BR_NONE = 3'b011,
      BR_LT   = 3'b100,
      BR_GE   = 3'b101,
      BR_LTU  = 3'b110,
      BR_GEU  = 3'b111
   } br_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   // Instruction fetch needs 4-byte aligned targets.
   function automatic logic word_aligned(input logic [1:0] lsbs);
      return (lsbs == 2'b00);
   endfunction

endpackage

// File: rtl/ex_branch_resolve_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
//   Pure combinational branch condition evaluation.
//   Ports: data1_i/data2_i  rs1/rs2 operands
//          op_i             branch_alu_op code
//          cond_o           1 when the branch/jump is taken
// ---------------------------------------------------------------------------
module branch_cmp
   import ex_branch_resolve_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  br_op_e          op_i,
   output logic            cond_o
);

   logic eq, lt_s, lt_u;

   assign eq   = (data1_i == data2_i);
   assign lt_s = ($signed(data1_i) < $signed(data2_i));
   assign lt_u = (data1_i < data2_i);

   always_comb begin
      cond_o = 1'b0;
      unique case (op_i)
         BR_EQ:   cond_o = eq;
         BR_NE:   cond_o = ~eq;
         BR_LT:   cond_o = lt_s;
         BR_GE:   cond_o = ~lt_s;
         BR_LTU:  cond_o = lt_u;
         BR_GEU:  cond_o = ~lt_u;
         BR_JUMP: cond_o = 1'b1;
         BR_NONE: cond_o = 1'b0;
         default: cond_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_branch_resolve.sv
// ---------------------------------------------------------------------------
// ex_branch_resolve
//   EX-stage branch resolution: decides taken/not-taken, computes target and
//   link address, registers the result (latency 1), pulses a redirect to
//   fetch and then squashes FLUSH_CYCLES unstalled cycles of younger work.
//   Ports:
//     clk_i, rst_n_i         clock, async active-low reset
//     in_valid_i, stall_i    live EX instruction, pipeline hold
//     flush_in_i             kill from a later stage (beats everything but reset)
//     branch_alu_op_i        br_op_e encoding
//     is_jalr_i              register-relative target
//     pc_i, data1_i, data2_i, imm_i  operands
//     out_valid_o, taken_o   registered result
//     redirect_o             one-cycle fetch redirect pulse
//     redirect_pc_o          target address
//     link_addr_o            pc+4
//     misalign_trap_o        one-cycle pulse, taken target not word aligned
//     squash_o               high while in FLUSH
//     taken_count_o          saturating redirect counter
// ---------------------------------------------------------------------------
module ex_branch_resolve
   import ex_branch_resolve_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   input  logic             stall_i,
   input  logic             flush_in_i,
   input  logic [2:0]       branch_alu_op_i,
   input  logic             is_jalr_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  data1_i,
   input  logic [XLEN-1:0]  data2_i,
   input  logic [XLEN-1:0]  imm_i,
   output logic             out_valid_o,
   output logic             taken_o,
   output logic             redirect_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic [XLEN-1:0]  link_addr_o,
   output logic             misalign_trap_o,
   output logic             squash_o,
   output logic [CNT_W-1:0] taken_count_o
);

   localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   state_e            state_q, state_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic              ov_q, ov_d, tk_q, tk_d, rd_q, rd_d, mis_q, mis_d;
   logic [XLEN-1:0]   rpc_q, rpc_d, link_q, link_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;

   logic              cond;
   logic [XLEN-1:0]   jalr_sum, target, link;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .data1_i (data1_i),
      .data2_i (data2_i),
      .op_i    (br_op_e'(branch_alu_op_i)),
      .cond_o  (cond)
   );

   assign jalr_sum = data1_i + imm_i;
   assign target   = is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_i + imm_i);
   assign link     = pc_i + XLEN'(4);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      ov_d    = ov_q;
      tk_d    = tk_q;
      rd_d    = 1'b0;     // pulses drop every cycle, stall included
      mis_d   = 1'b0;
      rpc_d   = rpc_q;
      link_d  = link_q;
      tcnt_d  = tcnt_q;
      if (flush_in_i) begin
         // The EX instruction (taken or not) is discarded.
         state_d = IDLE;
         fcnt_d  = '0;
         ov_d    = 1'b0;
         tk_d    = 1'b0;
      end else if (stall_i) begin
         // hold everything except the pulses
      end else if (state_q == FLUSH) begin
         ov_d   = 1'b0;
         tk_d   = 1'b0;
         fcnt_d = fcnt_q - FC_W'(1);
         if (fcnt_q == FC_W'(1)) state_d = IDLE;
      end else if (in_valid_i) begin
         ov_d   = 1'b1;
         tk_d   = cond;
         rpc_d  = target;
         link_d = link;
         if (cond) begin
            if (!word_aligned(target[1:0])) begin
               mis_d = 1'b1;
            end else begin
               rd_d = 1'b1;
               if (~&tcnt_q) tcnt_d = tcnt_q + CNT_W'(1);
               if (FLUSH_CYCLES > 0) begin
                  state_d = FLUSH;
                  fcnt_d  = FC_W'(FLUSH_CYCLES);
               end
            end
         end
      end else begin
         ov_d = 1'b0;
         tk_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         fcnt_q  <= '0;
         ov_q    <= 1'b0;
         tk_q    <= 1'b0;
         rd_q    <= 1'b0;
         mis_q   <= 1'b0;
         rpc_q   <= '0;
         link_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         ov_q    <= ov_d;
         tk_q    <= tk_d;
         rd_q    <= rd_d;
         mis_q   <= mis_d;
         rpc_q   <= rpc_d;
         link_q  <= link_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign out_valid_o     = ov_q;
   assign taken_o         = tk_q;
   assign redirect_o      = rd_q;
   assign redirect_pc_o   = rpc_q;
   assign link_addr_o     = link_q;
   assign misalign_trap_o = mis_q;
   assign squash_o        = (state_q == FLUSH);
   assign taken_count_o   = tcnt_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
module tb_ex_branch_resolve;
   import ex_branch_resolve_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 0, stall = 0, flush_in = 0, is_jalr = 0;
   logic [2:0]  op = 3'b011;
   logic [31:0] pc = 0, d1 = 0, d2 = 0, imm = 0;
   logic        ov, tk, rd, mis, sq;
   logic [31:0] rpc, link;
   logic [1:0]  tcnt;

   int total = 0, bad = 0;

   typedef struct {
      logic ov, tk, rd, mis, sq;
      logic [1:0] cnt;
      logic [31:0] rpc, link;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   ex_branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .stall_i(stall),
      .flush_in_i(flush_in), .branch_alu_op_i(op), .is_jalr_i(is_jalr),
      .pc_i(pc), .data1_i(d1), .data2_i(d2), .imm_i(imm),
      .out_valid_o(ov), .taken_o(tk), .redirect_o(rd), .redirect_pc_o(rpc),
      .link_addr_o(link), .misalign_trap_o(mis), .squash_o(sq),
      .taken_count_o(tcnt)
   );

   // Monitor: any cycle with visible activity must match the next expectation.
   int rec = 0;
   always @(negedge clk) begin
      if (rst_n && (ov || rd || mis || sq)) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output rec%0d: got ov=%0b tk=%0b rd=%0b mis=%0b sq=%0b, required no activity",
                     rec, ov, tk, rd, mis, sq);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (ov !== e.ov || tk !== e.tk || rd !== e.rd || mis !== e.mis ||
                sq !== e.sq || tcnt !== e.cnt || rpc !== e.rpc || link !== e.link) begin
               bad++;
               $display("FAIL rec%0d: got ov=%0b tk=%0b rd=%0b mis=%0b sq=%0b cnt=%0d rpc=%h link=%h, required ov=%0b tk=%0b rd=%0b mis=%0b sq=%0b cnt=%0d rpc=%h link=%h",
                        rec, ov, tk, rd, mis, sq, tcnt, rpc, link,
                        e.ov, e.tk, e.rd, e.mis, e.sq, e.cnt, e.rpc, e.link);
            end
         end
         rec++;
      end
   end

   task automatic expect_out(input logic eov, etk, erd, emis, esq,
                             input logic [1:0] ecnt, input logic [31:0] erpc, elink);
      exp_t e;
      e.ov = eov; e.tk = etk; e.rd = erd; e.mis = emis; e.sq = esq;
      e.cnt = ecnt; e.rpc = erpc; e.link = elink;
      q.push_back(e);
   endtask

   task automatic cyc(input logic v, input logic [2:0] o, input logic j,
                      input logic [31:0] p, a, b, im, input logic st, fl);
      in_valid = v; op = o; is_jalr = j; pc = p; d1 = a; d2 = b; imm = im;
      stall = st; flush_in = fl;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, BR_NONE, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ov, tk, rd, mis, sq, tcnt, rpc, link} !== '0) begin
         bad++;
         $display("FAIL reset_state: got ov=%0b tk=%0b rd=%0b mis=%0b sq=%0b cnt=%0d rpc=%h link=%h, required all zero",
                  ov, tk, rd, mis, sq, tcnt, rpc, link);
      end
      rst_n = 1'b1;
      idle(1);

      // BEQ taken, two squash cycles
      expect_out(1, 1, 1, 0, 1, 1, 32'h120, 32'h104);
      expect_out(0, 0, 0, 0, 1, 1, 32'h120, 32'h104);
      cyc(1, BR_EQ, 0, 32'h100, 5, 5, 32'h20, 0, 0);
      idle(2);

      // BLT signed: -1 < 1 taken
      expect_out(1, 1, 1, 0, 1, 2, 32'h210, 32'h204);
      expect_out(0, 0, 0, 0, 1, 2, 32'h210, 32'h204);
      cyc(1, BR_LT, 0, 32'h200, 32'hFFFF_FFFF, 1, 32'h10, 0, 0);
      idle(2);

      // BLTU: 0xFFFFFFFF < 1 false
      expect_out(1, 0, 0, 0, 0, 2, 32'h210, 32'h204);
      cyc(1, BR_LTU, 0, 32'h200, 32'hFFFF_FFFF, 1, 32'h10, 0, 0);
      idle(1);

      // JALR misaligned target 0x1002
      expect_out(1, 1, 0, 1, 0, 2, 32'h1002, 32'h44);
      cyc(1, BR_JUMP, 1, 32'h40, 32'h1003, 32'h55, 0, 0, 0);
      idle(1);

      // BNE taken, then stall 3 cycles inside FLUSH with live instructions
      expect_out(1, 1, 1, 0, 1, 3, 32'h340, 32'h304);
      for (int i = 0; i < 3; i++) expect_out(1, 1, 0, 0, 1, 3, 32'h340, 32'h304);
      expect_out(0, 0, 0, 0, 1, 3, 32'h340, 32'h304);
      cyc(1, BR_NE, 0, 32'h300, 1, 2, 32'h40, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, BR_JUMP, 0, 32'h500, 0, 0, 8, 1, 0);
      for (int i = 0; i < 2; i++) cyc(1, BR_JUMP, 0, 32'h500, 0, 0, 8, 0, 0);
      idle(1);

      // flush_in with a taken BNE in EX: discarded, no activity at all
      cyc(1, BR_NE, 0, 32'h400, 1, 2, 32'h10, 0, 1);
      idle(1);

      // flush_in during FLUSH, then a normal evaluation right after
      expect_out(1, 1, 1, 0, 1, 3, 32'h700, 32'h604);
      cyc(1, BR_JUMP, 0, 32'h600, 0, 32'h1234, 32'h100, 0, 0);
      cyc(0, BR_NONE, 0, 0, 0, 0, 0, 0, 1);
      expect_out(1, 0, 0, 0, 0, 3, 32'h804, 32'h804);
      cyc(1, BR_EQ, 0, 32'h800, 1, 2, 4, 0, 0);
      idle(1);

      // link/target wrap at 2^32
      expect_out(1, 0, 0, 0, 0, 3, 32'h4, 32'h0);
      cyc(1, BR_NONE, 0, 32'hFFFF_FFFC, 7, 7, 8, 0, 0);
      idle(1);

      // 5th redirect: counter stays saturated at 3; JALR bit0 cleared
      expect_out(1, 1, 1, 0, 1, 3, 32'h2004, 32'h904);
      expect_out(0, 0, 0, 0, 1, 3, 32'h2004, 32'h904);
      cyc(1, BR_JUMP, 1, 32'h900, 32'h2001, 0, 3, 0, 0);
      idle(3);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL missing_outputs: got %0d expectations left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_branch_resolve.md
Name: ex_branch_resolve

Overview:
- EX-stage branch resolution unit. Consumes the 3-bit branch_alu_op control code, operands and PC produced by the EX control decode.
- Decides taken or not-taken, computes target and link addresses, and registers the result.
- Issues a one-cycle redirect to fetch, then sequences a fixed-length squash of younger in-flight instructions.
- Sits between the EX operand muxes and the IF PC-select logic.

Parameters:
- XLEN, 32, datapath and address width.
- FLUSH_CYCLES, 2, number of unstalled cycles squashed after a redirect; 0 means no squash window.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX slot holds a live instruction.
- stall  in  1  pipeline stall; holds all state.
- flush_in  in  1  external kill from a later stage (trap).
- branch_alu_op  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, 010 unconditional jump, 011 not a branch.
- is_jalr  in  1  jump target is register-relative.
- pc  in  XLEN  PC of the EX instruction.
- data1  in  XLEN  rs1 value.
- data2  in  XLEN  rs2 value.
- imm  in  XLEN  sign-extended immediate.
- out_valid  out  1  registered result valid.
- taken  out  1  registered taken decision.
- redirect  out  1  one-cycle pulse: fetch from redirect_pc.
- redirect_pc  out  XLEN  branch or jump target.
- link_addr  out  XLEN  pc+4 for the rd writeback of JAL/JALR.
- misalign_trap  out  1  one-cycle pulse: taken target not 4-byte aligned.
- squash  out  1  high while in FLUSH state.
- taken_count  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, flush counter 0, all outputs 0.
- Evaluation
  - Occurs on a rising edge with in_valid=1, stall=0, flush_in=0 and state=IDLE.
  - Results appear on the next cycle, a latency of 1.
  - Compares are signed for 100/101, unsigned for 110/111, equality for 000/001.
  - 010 is always taken; 011 is never taken; 010 and 011 ignore data2.
  - Target: is_jalr ? (data1+imm) with bit0 cleared : pc+imm. Modulo 2^XLEN, wraps silently.
  - link_addr = pc+4, wraps. Computed for every evaluated instruction.
- Taken with target[1:0]≠0: misalign_trap=1, redirect=0, no state change, taken_count unchanged.
- Taken and aligned:
  - redirect=1 and taken_count increments, saturating at all-ones.
  - If FLUSH_CYCLES>0: enter FLUSH with counter=FLUSH_CYCLES.
- Not taken: out_valid=1, taken=0, redirect=0.
- FLUSH state
  - squash=1; out_valid=0 regardless of in_valid.
  - Counter decrements each cycle with stall=0; it holds under stall.
  - Counter 1→0 returns to IDLE. The next cycle evaluates normally.
  - A new redirect cannot start while in FLUSH.
- Stall
  - Holds state, counter, out_valid, taken, redirect_pc, link_addr and taken_count.
  - redirect and misalign_trap are pulses: forced to 0 on the cycle after they assert, even if stall is high. This prevents double redirect.
- flush_in has priority over everything except reset.
  - Next cycle: state IDLE, counter 0, out_valid/redirect/misalign_trap/squash 0. taken_count kept.
  - Applies even if a taken branch is in EX that cycle; that branch is discarded.
- Reset mid-FLUSH: immediate return to reset values.

Decomposition:
- Shared package holds:
  - branch_alu_op encodings: BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP, BR_NONE.
  - FSM state enum {IDLE, FLUSH}.
  - The decode unit uses the same constants.
- One combinational sub-module, branch_cmp: data1, data2, op → cond. Sequencing stays in the top.

Test Plan:
- BEQ taken: op=000, data1=data2=5, pc=0x100, imm=0x20 → next cycle redirect=1, redirect_pc=0x120, squash high 2 cycles, taken_count=1.
- BLT vs BLTU: data1=0xFFFFFFFF, data2=1.
  - op=100 → taken.
  - op=110 → not taken, out_valid=1, redirect=0.
- JALR: data1=0x1003, imm=0, is_jalr=1, op=010, pc=0x40 → redirect_pc=0x1002; misalign_trap=1, redirect=0; link_addr=0x44.
- Stall in FLUSH: stall high 3 cycles starting with the cycle after redirect → redirect pulse lasts exactly 1 cycle; squash lasts 2+3 cycles; in_valid instructions during FLUSH give out_valid=0.
- flush_in coincident with taken BNE → no redirect, squash=0, taken_count unchanged. Also: flush_in during FLUSH returns to IDLE the next cycle.
- Wrap and saturation: pc=0xFFFFFFFC gives link_addr=0; with CNT_W=2, 5 redirects give taken_count=3.
